// File: rtl/lightsaber_blade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : lightsaber_blade_driver
//  Description : Animates the blade bars (ignite, hold, retract) one segment
//                per prescaled step from the registered blade configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module lightsaber_blade_driver #(
    parameter int LEN      = 8,
    parameter int STEP_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [1:0]     Config,
    output logic [LEN-1:0] BladeA,
    output logic [LEN-1:0] BladeB,
    output logic           Hilt,
    output logic           Busy,
    output logic           Ready
);

    localparam int C_LVL_W = $clog2(LEN + 1);
    localparam int C_PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [C_LVL_W-1:0] C_LVL_MAX = C_LVL_W'(LEN);
    localparam logic [C_LVL_W-1:0] C_LVL_PEN = C_LVL_W'(LEN - 1);
    localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_IGNITE  = 2'd1,
        S_ON      = 2'd2,
        S_RETRACT = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_LVL_W-1:0]   r_lvl;
    logic [C_LVL_W-1:0]   w_lvl_nxt;
    logic [1:0]           r_cfg;
    logic [1:0]           w_cfg_nxt;
    logic [C_PRE_W-1:0]   r_presc;
    logic [C_PRE_W-1:0]   w_presc_nxt;
    logic                 w_want;
    logic                 w_abort;
    logic                 w_step;
    logic [LEN-1:0]       w_therm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_lvl   <= '0;
            r_cfg   <= 2'd0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lvl   <= w_lvl_nxt;
            r_cfg   <= w_cfg_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    assign w_want  = en && (Config != 2'd0);
    assign w_abort = !w_want || (Config != r_cfg);
    assign w_step  = (r_presc == C_PRE_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_lvl_nxt   = r_lvl;
        w_cfg_nxt   = r_cfg;
        case (r_state)
            S_OFF: begin
                if (w_want) begin
                    w_cfg_nxt   = Config;
                    w_state_nxt = S_IGNITE;
                end
            end
            S_IGNITE: begin
                if (w_abort) begin
                    w_state_nxt = S_RETRACT;
                end else if (w_step && (r_lvl != C_LVL_MAX)) begin
                    w_lvl_nxt = r_lvl + C_LVL_W'(1);
                    if (r_lvl == C_LVL_PEN) begin
                        w_state_nxt = S_ON;
                    end
                end
            end
            S_ON: begin
                if (w_abort) begin
                    w_state_nxt = S_RETRACT;
                end
            end
            default: begin
                // The dark check wins over stepping, so a retraction never
                // underflows and only ever exits once fully retracted.
                if (r_lvl == '0) begin
                    if (w_want) begin
                        w_cfg_nxt   = Config;
                        w_state_nxt = S_IGNITE;
                    end else begin
                        w_cfg_nxt   = 2'd0;
                        w_state_nxt = S_OFF;
                    end
                end else if (w_step) begin
                    w_lvl_nxt = r_lvl - C_LVL_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        w_presc_nxt = r_presc + C_PRE_W'(1);
        if ((w_state_nxt != r_state) || w_step) begin
            w_presc_nxt = '0;
        end
    end

    always_comb begin
        w_therm = '0;
        for (int i = 0; i < LEN; i++) begin
            w_therm[i] = (i < int'(r_lvl));
        end
    end

    assign BladeA = (r_cfg != 2'd0) ? w_therm : '0;
    assign BladeB = (r_cfg == 2'd2) ? w_therm : '0;
    assign Hilt   = (r_cfg == 2'd3) && (r_lvl != '0);
    assign Busy   = (r_state == S_IGNITE) || (r_state == S_RETRACT);
    assign Ready  = (r_state == S_ON);

endmodule
`default_nettype wire

// File: tb/tb_lightsaber_blade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lightsaber_blade_driver
//  Description : Directed stimulus with a cycle-level blade model and
//                hand-computed checkpoints for lightsaber_blade_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lightsaber_blade_driver;

    localparam int LEN      = 8;
    localparam int STEP_DIV = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic [1:0]     Config = 2'd0;
    logic [LEN-1:0] BladeA;
    logic [LEN-1:0] BladeB;
    logic           Hilt;
    logic           Busy;
    logic           Ready;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    lightsaber_blade_driver #(.LEN(LEN), .STEP_DIV(STEP_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .Config (Config),
        .BladeA (BladeA),
        .BladeB (BladeB),
        .Hilt   (Hilt),
        .Busy   (Busy),
        .Ready  (Ready)
    );

    always #5 clk = ~clk;

    // Model: mode 0=dark 1=extending 2=lit 3=retracting; tk = cycles spent in
    // the current mode, so a step lands on every STEP_DIV-th cycle of it.
    typedef struct packed {
        int md;
        int lv;
        int cf;
        int tk;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_next(mstate_t s, bit r, bit e, logic [1:0] c);
        mstate_t n;
        bit want;
        bit step;
        n = s;
        if (r) return '0;
        want = e && (c != 2'd0);
        step = (s.tk % STEP_DIV) == (STEP_DIV - 1);
        n.tk = s.tk + 1;
        if (s.md == 0) begin
            if (want) begin n.md = 1; n.cf = int'(c); n.tk = 0; end
        end else if (s.md == 1) begin
            if (!want || int'(c) != s.cf) begin
                n.md = 3; n.tk = 0;
            end else if (step) begin
                n.lv = s.lv + 1;
                if (n.lv == LEN) begin n.md = 2; n.tk = 0; end
            end
        end else if (s.md == 2) begin
            if (!want || int'(c) != s.cf) begin n.md = 3; n.tk = 0; end
        end else begin
            if (s.lv == 0) begin
                n.tk = 0;
                if (want) begin n.md = 1; n.cf = int'(c); end
                else      begin n.md = 0; n.cf = 0; end
            end else if (step) begin
                n.lv = s.lv - 1;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m = model_next(m, rst, en, Config);
        end
    end

    initial begin
        int bar;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                bar = (1 << m.lv) - 1;
                check("model BladeA", int'(BladeA), (m.cf != 0) ? bar : 0);
                check("model BladeB", int'(BladeB), (m.cf == 2) ? bar : 0);
                check("model Hilt",   int'(Hilt),   int'((m.cf == 3) && (m.lv != 0)));
                check("model Busy",   int'(Busy),   int'((m.md == 1) || (m.md == 3)));
                check("model Ready",  int'(Ready),  int'(m.md == 2));
            end
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held with a valid Double request pending.
        rst = 1'b1; en = 1'b1; Config = 2'd2;
        run(1);
        chk_on = 1'b1;
        run(1);
        check("reset BladeA", int'(BladeA), 0);
        check("reset BladeB", int'(BladeB), 0);
        check("reset Busy",   int'(Busy),   0);
        check("reset Ready",  int'(Ready),  0);
        rst = 1'b0;
        run(1);
        check("ignite after reset Busy", int'(Busy), 1);
        run(4);
        check("double c5 BladeA", int'(BladeA), 8'h01);
        check("double c5 BladeB", int'(BladeB), 8'h01);
        run(28);
        check("double c33 BladeA", int'(BladeA), 8'hFF);
        check("double c33 BladeB", int'(BladeB), 8'hFF);
        check("double c33 Ready",  int'(Ready),  1);
        check("double c33 Busy",   int'(Busy),   0);

        // Power-off while lit.
        en = 1'b0;
        run(1);
        check("poweroff Ready", int'(Ready), 0);
        check("poweroff Busy",  int'(Busy),  1);
        run(4);
        check("poweroff first step", int'(BladeA), 8'h7F);
        run(28);
        check("poweroff dark BladeA", int'(BladeA), 8'h00);
        check("poweroff dark Busy",   int'(Busy),   1);
        run(1);
        check("poweroff OFF Busy", int'(Busy), 0);

        // Single ignition.
        en = 1'b1; Config = 2'd1;
        run(1);
        check("single c1 Busy", int'(Busy), 1);
        run(4);
        check("single c5 BladeA", int'(BladeA), 8'h01);
        run(28);
        check("single c33 BladeA", int'(BladeA), 8'hFF);
        check("single c33 BladeB", int'(BladeB), 8'h00);
        check("single c33 Ready",  int'(Ready),  1);

        // Config change while lit: full retraction, then Double ignition.
        Config = 2'd2;
        run(1);
        check("cfgchg BladeB stays dark", int'(BladeB), 8'h00);
        run(32);
        check("cfgchg retracted BladeA", int'(BladeA), 8'h00);
        run(1);
        check("cfgchg reignite Busy", int'(Busy), 1);
        run(4);
        check("cfgchg reignite BladeB", int'(BladeB), 8'h01);
        run(28);
        check("cfgchg full BladeB", int'(BladeB), 8'hFF);

        // Back to dark, then Hilted with an abort at lvl 3.
        en = 1'b0;
        run(34);
        check("dark before hilted Busy", int'(Busy), 0);
        en = 1'b1; Config = 2'd3;
        run(5);
        check("hilted c5 Hilt",   int'(Hilt),   1);
        check("hilted c5 BladeB", int'(BladeB), 8'h00);
        run(8);
        check("hilted lvl3 BladeA", int'(BladeA), 8'h07);
        en = 1'b0;
        run(1);
        check("abort BladeA held", int'(BladeA), 8'h07);
        en = 1'b1;
        run(4);
        check("retract not aborted BladeA", int'(BladeA), 8'h03);
        check("retract not aborted Busy",   int'(Busy),   1);
        run(9);
        check("resume ignite Hilt dark", int'(Hilt), 0);
        run(4);
        check("resume ignite BladeA", int'(BladeA), 8'h01);

        // Reset pulse mid-ignite.
        run(6);
        rst = 1'b1;
        run(1);
        check("midreset BladeA", int'(BladeA), 0);
        check("midreset Hilt",   int'(Hilt),   0);
        check("midreset Busy",   int'(Busy),   0);
        rst = 1'b0;
        run(1);
        check("after midreset Busy", int'(Busy), 1);
        en = 1'b0;
        run(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
